// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller: FSM states,
// comparator flag classes and the flag-to-class mapping used by the decoder.
package sar_search_pkg;

    localparam int SAR_DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE,
        TEST
    } sar_state_e;

    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT,
        CMP_INVALID
    } cmp_class_e;

    // Exact-match case: X or Z on any flag falls through to CMP_INVALID.
    function automatic cmp_class_e decodeFlags(input logic lt, input logic eq, input logic gt);
        cmp_class_e flagClass;
        case ({lt, eq, gt})
            3'b100:  flagClass = CMP_LT;
            3'b010:  flagClass = CMP_EQ;
            3'b001:  flagClass = CMP_GT;
            default: flagClass = CMP_INVALID;
        endcase
        return flagClass;
    endfunction

endpackage

// File: rtl/cmp_flag_decoder.sv
// Combinational classifier for the comparator's less/equal/greater flags;
// anything other than a clean one-hot pattern is reported as CMP_INVALID.
import sar_search_pkg::*;

module cmp_flag_decoder (
    input  logic       lt_i,
    input  logic       eq_i,
    input  logic       gt_i,
    output cmp_class_e flagClass_o
);

    always_comb begin
        flagClass_o = decodeFlags(lt_i, eq_i, gt_i);
    end

endmodule

// File: rtl/sar_search_controller.sv
// Successive-approximation search controller driving the comparator B operand.
// Define SAR_EARLY_EXIT_EN to finish a search as soon as the comparator reports EQ.
import sar_search_pkg::*;

module sar_search_controller #(
    parameter int WIDTH = SAR_DEFAULT_WIDTH
) (
    input  logic                       Clock_In,
    input  logic                       Reset_In,
    input  logic                       Start_In,
    output logic [WIDTH-1:0]           Trial_Out,
    input  logic                       A_Less_Than_B_In,
    input  logic                       A_Equal_To_B_In,
    input  logic                       A_Greater_Than_B_In,
    output logic                       Busy_Out,
    output logic                       Done_Out,
    output logic [WIDTH-1:0]           Result_Out,
    output logic [$clog2(WIDTH+1)-1:0] Cycles_Out,
    output logic                       Error_Out
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    sar_state_e        state_q, state_d;
    logic [WIDTH-1:0]  trial_q, trial_d;
    logic [IW-1:0]     bitIdx_q, bitIdx_d;
    logic [CW-1:0]     evalCount_q, evalCount_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [CW-1:0]     cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    cmp_class_e        flagClass;
    logic [WIDTH-1:0]  nextTrial;
    logic              finishNow;
    logic              abortNow;

    cmp_flag_decoder u_decoder (
        .lt_i        (A_Less_Than_B_In),
        .eq_i        (A_Equal_To_B_In),
        .gt_i        (A_Greater_Than_B_In),
        .flagClass_o (flagClass)
    );

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q     <= IDLE;
            trial_q     <= '0;
            bitIdx_q    <= '0;
            evalCount_q <= '0;
            result_q    <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            trial_q     <= trial_d;
            bitIdx_q    <= bitIdx_d;
            evalCount_q <= evalCount_d;
            result_q    <= result_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trial_d     = trial_q;
        bitIdx_d    = bitIdx_q;
        evalCount_d = evalCount_q;
        result_d    = result_q;
        cycles_d    = cycles_q;
        done_d      = 1'b0;
        error_d     = error_q;
        nextTrial   = trial_q;
        finishNow   = 1'b0;
        abortNow    = 1'b0;

        case (state_q)
            IDLE: begin
                trial_d = '0;
                if (Start_In) begin
                    state_d     = TEST;
                    trial_d     = {1'b1, {(WIDTH-1){1'b0}}};
                    bitIdx_d    = IW'(WIDTH - 1);
                    evalCount_d = '0;
                    error_d     = 1'b0;
                end
            end

            TEST: begin
                evalCount_d = evalCount_q + CW'(1);

                // EQ keeps the bit like GT; only the early-exit build stops on it.
                case (flagClass)
                    CMP_LT: nextTrial[bitIdx_q] = 1'b0;
                    CMP_GT: nextTrial = trial_q;
                    CMP_EQ: begin
`ifdef SAR_EARLY_EXIT_EN
                        finishNow = 1'b1;
`else
                        finishNow = 1'b0;
`endif
                    end
                    default: abortNow = 1'b1;
                endcase

                if (abortNow) begin
                    state_d  = IDLE;
                    trial_d  = '0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    result_d = '0;
                    cycles_d = evalCount_q + CW'(1);
                end else if (finishNow || (bitIdx_q == '0)) begin
                    state_d  = IDLE;
                    trial_d  = '0;
                    done_d   = 1'b1;
                    result_d = nextTrial;
                    cycles_d = evalCount_q + CW'(1);
                end else begin
                    nextTrial[bitIdx_q - IW'(1)] = 1'b1;
                    trial_d  = nextTrial;
                    bitIdx_d = bitIdx_q - IW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                trial_d = '0;
            end
        endcase
    end

    assign Trial_Out  = trial_q;
    assign Busy_Out   = (state_q == TEST);
    assign Done_Out   = done_q;
    assign Result_Out = result_q;
    assign Cycles_Out = cycles_q;
    assign Error_Out  = error_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench: a behavioural 4-bit comparator answers the controller's trials.
// Expectations follow SAR_EARLY_EXIT_EN so the bench serves both builds.
module tb_sar_search_controller;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

`ifdef SAR_EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    logic             clock;
    logic             reset;
    logic             startIn;
    logic [WIDTH-1:0] trialOut;
    wire              cmpLess;
    wire              cmpEqual;
    wire              cmpGreater;
    logic             busyOut;
    logic             doneOut;
    logic [WIDTH-1:0] resultOut;
    logic [CW-1:0]    cyclesOut;
    logic             errorOut;

    logic [WIDTH-1:0] aValue;
    logic             cmpReset;

    int checkCount = 0;
    int errorCount = 0;

    // Comparator responder: floats its flags while held in reset.
    assign cmpLess    = cmpReset ? 1'bz : (aValue <  trialOut);
    assign cmpEqual   = cmpReset ? 1'bz : (aValue == trialOut);
    assign cmpGreater = cmpReset ? 1'bz : (aValue >  trialOut);

    sar_search_controller #(.WIDTH(WIDTH)) dut (
        .Clock_In            (clock),
        .Reset_In            (reset),
        .Start_In            (startIn),
        .Trial_Out           (trialOut),
        .A_Less_Than_B_In    (cmpLess),
        .A_Equal_To_B_In     (cmpEqual),
        .A_Greater_Than_B_In (cmpGreater),
        .Busy_Out            (busyOut),
        .Done_Out            (doneOut),
        .Result_Out          (resultOut),
        .Cycles_Out          (cyclesOut),
        .Error_Out           (errorOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses Start for one cycle and follows the search; expTrials lists trials MSB-nibble first.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] aVal,
                                 input logic [15:0] expTrials, input int expEvals,
                                 input logic [WIDTH-1:0] expResult);
        aValue = aVal;
        @(negedge clock);
        startIn = 1'b1;
        @(negedge clock);
        startIn = 1'b0;
        checkOutput({tag, " busy"}, busyOut, 1'b1);
        checkOutput({tag, " errorCleared"}, errorOut, 1'b0);
        for (int i = 0; i < expEvals; i++) begin
            checkOutput($sformatf("%s trial%0d", tag, i), trialOut, expTrials[15 - 4*i -: 4]);
            @(negedge clock);
        end
        checkOutput({tag, " done"}, doneOut, 1'b1);
        checkOutput({tag, " busyLow"}, busyOut, 1'b0);
        checkOutput({tag, " result"}, resultOut, expResult);
        checkOutput({tag, " cycles"}, cyclesOut, expEvals);
        checkOutput({tag, " error"}, errorOut, 1'b0);
        @(negedge clock);
        checkOutput({tag, " donePulse"}, doneOut, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        startIn  = 1'b0;
        aValue   = '0;
        cmpReset = 1'b0;
        #12;
        checkOutput("rst trial", trialOut, 0);
        checkOutput("rst busy", busyOut, 0);
        checkOutput("rst done", doneOut, 0);
        checkOutput("rst result", resultOut, 0);
        checkOutput("rst cycles", cyclesOut, 0);
        checkOutput("rst error", errorOut, 0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus("a0101", 4'b0101, 16'b1000_0100_0110_0101, 4, 4'b0101);
        if (EARLY != 0)
            applyStimulus("a1000", 4'b1000, 16'b1000_0000_0000_0000, 1, 4'b1000);
        else
            applyStimulus("a1000", 4'b1000, 16'b1000_1100_1010_1001, 4, 4'b1000);
        applyStimulus("a0000", 4'b0000, 16'b1000_0100_0010_0001, 4, 4'b0000);
        applyStimulus("a1111", 4'b1111, 16'b1000_1100_1110_1111, 4, 4'b1111);

        // Start pulsed mid-search must not restart or disturb the search.
        aValue = 4'b0011;
        @(negedge clock);
        startIn = 1'b1;
        @(negedge clock);
        startIn = 1'b0;
        checkOutput("busyStart trial0", trialOut, 4'b1000);
        @(negedge clock);
        startIn = 1'b1;
        checkOutput("busyStart trial1", trialOut, 4'b0100);
        @(negedge clock);
        startIn = 1'b0;
        checkOutput("busyStart trial2", trialOut, 4'b0010);
        @(negedge clock);
        checkOutput("busyStart trial3", trialOut, 4'b0011);
        @(negedge clock);
        checkOutput("busyStart done", doneOut, 1'b1);
        checkOutput("busyStart result", resultOut, 4'b0011);
        @(negedge clock);
        checkOutput("busyStart idle", busyOut, 1'b0);

        // Start held high through Done launches the next search in the Done cycle.
        aValue = 4'b1011;
        startIn = 1'b1;
        @(negedge clock);
        repeat (4) @(negedge clock);
        checkOutput("hold done", doneOut, 1'b1);
        checkOutput("hold result", resultOut, 4'b1011);
        @(negedge clock);
        startIn = 1'b0;
        checkOutput("hold restartBusy", busyOut, 1'b1);
        checkOutput("hold restartTrial", trialOut, 4'b1000);
        checkOutput("hold noDone", doneOut, 1'b0);
        repeat (4) @(negedge clock);
        checkOutput("hold done2", doneOut, 1'b1);
        checkOutput("hold cycles2", cyclesOut, 4);

        // Comparator reset mid-search floats the flags: abort with error.
        @(negedge clock);
        aValue = 4'b0110;
        startIn = 1'b1;
        @(negedge clock);
        startIn = 1'b0;
        @(negedge clock);
        checkOutput("abort trial1", trialOut, 4'b0100);
        cmpReset = 1'b1;
        @(negedge clock);
        checkOutput("abort done", doneOut, 1'b1);
        checkOutput("abort error", errorOut, 1'b1);
        checkOutput("abort result", resultOut, 0);
        checkOutput("abort busy", busyOut, 1'b0);
        checkOutput("abort trialIdle", trialOut, 0);
        cmpReset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("abort donePulse", doneOut, 1'b0);
        checkOutput("abort errorHeld", errorOut, 1'b1);
        applyStimulus("recover", 4'b0101, 16'b1000_0100_0110_0101, 4, 4'b0101);

        // Asynchronous reset at the second evaluation clears everything, no Done.
        aValue = 4'b1011;
        @(negedge clock);
        startIn = 1'b1;
        @(negedge clock);
        startIn = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midRst trial", trialOut, 0);
        checkOutput("midRst busy", busyOut, 0);
        checkOutput("midRst result", resultOut, 0);
        checkOutput("midRst cycles", cyclesOut, 0);
        checkOutput("midRst error", errorOut, 0);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midRst noDone", doneOut, 0);
        @(negedge clock);
        checkOutput("midRst stillNoDone", doneOut, 0);
        checkOutput("midRst idle", busyOut, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
